// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage turning pipeline accesses into single-beat memory requests.
// Latency: launch cycle plus ack cycle at minimum; load result is registered one cycle after ack.
// Backpressure: stall holds the pipeline until mem_ack or the wait timeout ends the access.

module lsu_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                store,
   input  logic [2:0]          funct3,
   input  logic [DATA_W-1:0]   op_b,
   input  logic [ADDR_W-1:0]   alu_out_address,
   output logic                stall,
   output logic [DATA_W-1:0]   load_data,
   output logic                load_valid,
   output logic                access_err,
   output logic                timeout_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_mask,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack
);

   localparam int MASK_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(MASK_W);
   localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                is_load_q;
   logic [2:0]          funct3_q;
   logic [OFF_W-1:0]    off_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [MASK_W-1:0]   mem_mask_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W-1:0]   load_data_q;
   logic                load_valid_q;

   logic [OFF_W-1:0]    lane_off;
   logic                funct3_ok;
   logic                aligned;
   logic                faulty;
   logic                req_any;
   logic                is_busy;
   logic                launch;
   logic                timeout_hit;
   logic [MASK_W-1:0]   base_mask;
   logic [MASK_W-1:0]   mem_mask_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic [DATA_W-1:0]   rdata_sh;
   logic [DATA_W-1:0]   load_data_d;

   assign lane_off = alu_out_address[OFF_W-1:0];
   assign req_any  = load | store;
   assign is_busy  = (state_q == BUSY);

   // Legal size/sign encodings; the doubleword forms only exist on a 64-bit bus.
   always_comb begin
      funct3_ok = 1'b0;
      if (load) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
            3'b011, 3'b110:                         funct3_ok = (DATA_W == 64);
            default:                                funct3_ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b011:                 funct3_ok = (DATA_W == 64);
            default:                funct3_ok = 1'b0;
         endcase
      end
   end

   // Natural alignment: the access size in bytes must divide the address.
   always_comb begin
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~alu_out_address[0];
         2'b10:   aligned = (alu_out_address[1:0] == 2'b00);
         default: aligned = (alu_out_address[2:0] == 3'b000);
      endcase
   end

   assign faulty = (load & store) | ~funct3_ok | ~aligned;

   // Byte-lane mask, lane-shifted store data and bus-aligned address for the launch.
   always_comb begin
      case (funct3[1:0])
         2'b00:   base_mask = MASK_W'(8'h01);
         2'b01:   base_mask = MASK_W'(8'h03);
         2'b10:   base_mask = MASK_W'(8'h0F);
         default: base_mask = MASK_W'(8'hFF);
      endcase
      mem_mask_d  = base_mask << lane_off;
      mem_wdata_d = op_b << {lane_off, 3'b000};
      mem_addr_d  = {alu_out_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   end

   // Bring the addressed lanes down to bit 0, then sign- or zero-extend by size.
   always_comb begin
      rdata_sh = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data_d = DATA_W'($signed(rdata_sh[7:0]));
         3'b001:  load_data_d = DATA_W'($signed(rdata_sh[15:0]));
         3'b010:  load_data_d = DATA_W'($signed(rdata_sh[31:0]));
         3'b100:  load_data_d = DATA_W'(rdata_sh[7:0]);
         3'b101:  load_data_d = DATA_W'(rdata_sh[15:0]);
         3'b110:  load_data_d = DATA_W'(rdata_sh[31:0]);
         default: load_data_d = rdata_sh;
      endcase
   end

   // An ack in the same cycle beats the timeout; reset silences every pulse.
   assign launch      = ~rst & ~is_busy & req_any & ~faulty;
   assign timeout_hit = (TIMEOUT_CYC != 0) && is_busy && !mem_ack &&
                        (cnt_q == CNT_W'(TIMEOUT_CYC));

   assign access_err  = ~rst & ~is_busy & req_any & faulty;
   assign timeout_err = ~rst & timeout_hit;
   assign mem_req     = ~rst & is_busy & ~timeout_hit;
   assign stall       = launch | (~rst & is_busy & ~mem_ack & ~timeout_hit);

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_mask   = mem_mask_q;
   assign mem_wdata  = mem_wdata_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;

   // Access FSM: capture on launch, wait for ack or timeout, retire load data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         is_load_q    <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_mask_q   <= '0;
         mem_wdata_q  <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q     <= BUSY;
                  cnt_q       <= '0;
                  is_load_q   <= load;
                  funct3_q    <= funct3;
                  off_q       <= lane_off;
                  mem_we_q    <= store;
                  mem_addr_q  <= mem_addr_d;
                  mem_mask_q  <= mem_mask_d;
                  mem_wdata_q <= mem_wdata_d;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state_q <= IDLE;
                  if (is_load_q) begin
                     load_data_q  <= load_data_d;
                     load_valid_q <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed bench for lsu_stage on a 32-bit bus (timeout 4) and a 64-bit bus (timeout off).
// Expectations come from a transaction-level model; a compare process checks every cycle.
// Driver advances one cycle at a time, so every run ends after a fixed number of cycles.

module tb_lsu_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 32-bit instance signals
   logic        a_rst, a_load, a_store, a_mem_ack;
   logic [2:0]  a_funct3;
   logic [31:0] a_op_b, a_addr, a_mem_rdata;
   logic        a_stall, a_load_valid, a_access_err, a_timeout_err, a_mem_req, a_mem_we;
   logic [31:0] a_load_data, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_mask;

   // 64-bit instance signals
   logic        b_rst, b_load, b_store, b_mem_ack;
   logic [2:0]  b_funct3;
   logic [63:0] b_op_b, b_mem_rdata;
   logic [31:0] b_addr;
   logic        b_stall, b_load_valid, b_access_err, b_timeout_err, b_mem_req, b_mem_we;
   logic [63:0] b_load_data, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_mask;

   lsu_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_a (
      .clk(clk), .rst(a_rst), .load(a_load), .store(a_store), .funct3(a_funct3),
      .op_b(a_op_b), .alu_out_address(a_addr), .stall(a_stall),
      .load_data(a_load_data), .load_valid(a_load_valid),
      .access_err(a_access_err), .timeout_err(a_timeout_err),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_mask(a_mem_mask), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack));

   lsu_stage #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(0)) u_b (
      .clk(clk), .rst(b_rst), .load(b_load), .store(b_store), .funct3(b_funct3),
      .op_b(b_op_b), .alu_out_address(b_addr), .stall(b_stall),
      .load_data(b_load_data), .load_valid(b_load_valid),
      .access_err(b_access_err), .timeout_err(b_timeout_err),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_mask(b_mem_mask), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack));

   // Model expectations per instance (0 = 32-bit, 1 = 64-bit)
   bit          chk_en [2];
   logic        e_stall [2], e_req [2], e_aerr [2], e_terr [2], e_lv [2], e_we [2], e_zero [2];
   logic [63:0] e_addr [2], e_wdata [2], e_ld [2];
   logic [7:0]  e_mask [2];

   // Observations used by the literal checks
   int          stall_seen [2], lv_seen [2], aerr_seen [2], terr_seen [2], req_seen [2];
   bit          cap_v [2];
   logic [63:0] cap_addr [2], cap_wdata [2];
   logic [7:0]  cap_mask [2];
   logic        cap_we [2];

   // ---------------- reference model (arithmetic on the access rules) ----------------
   function automatic logic [63:0] trunc(input logic [63:0] v, input int w);
      return (w == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
   endfunction

   function automatic bit f_legal(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [63:0] addr, input int w);
      int nb;
      if (ld && st) return 1'b0;
      if (!ld && !st) return 1'b0;
      if (ld) begin
         if (f3 == 3'b111) return 1'b0;
         if ((f3 == 3'b011 || f3 == 3'b110) && w != 64) return 1'b0;
      end else begin
         if (f3[2]) return 1'b0;
         if (f3 == 3'b011 && w != 64) return 1'b0;
      end
      nb = 1 << f3[1:0];
      return (addr % nb) == 0;
   endfunction

   function automatic int f_off(input logic [63:0] addr, input int w);
      return int'(addr % (w / 8));
   endfunction

   function automatic logic [63:0] f_maddr(input logic [63:0] addr, input int w);
      return addr - (addr % (w / 8));
   endfunction

   function automatic logic [7:0] f_mask(input logic [2:0] f3, input logic [63:0] addr, input int w);
      int nb;
      nb = 1 << f3[1:0];
      return 8'(((1 << nb) - 1) << f_off(addr, w));
   endfunction

   function automatic logic [63:0] f_wdata(input logic [63:0] opb, input logic [63:0] addr, input int w);
      return trunc(opb << (8 * f_off(addr, w)), w);
   endfunction

   function automatic logic [63:0] f_load(input logic [63:0] rd, input logic [2:0] f3,
                                          input logic [63:0] addr, input int w);
      int bits;
      logic [63:0] v, keep;
      bits = 8 * (1 << f3[1:0]);
      v = trunc(rd, w) >> (8 * f_off(addr, w));
      keep = (bits < 64) ? ((64'd1 << bits) - 64'd1) : ~64'd0;
      v = v & keep;
      if (!f3[2] && v[bits-1]) v = v | ~keep;
      return trunc(v, w);
   endfunction

   // ---------------- comparison helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cmp_inst(input int i, input logic stl, input logic req, input logic aerr,
                           input logic terr, input logic lv, input logic we,
                           input logic [63:0] ld, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [7:0] mk);
      string p;
      logic [63:0] lm;
      if (!chk_en[i]) return;
      p = (i == 0) ? "a" : "b";
      chk({p, ".stall"},       64'(stl),  64'(e_stall[i]));
      chk({p, ".mem_req"},     64'(req),  64'(e_req[i]));
      chk({p, ".access_err"},  64'(aerr), 64'(e_aerr[i]));
      chk({p, ".timeout_err"}, 64'(terr), 64'(e_terr[i]));
      chk({p, ".load_valid"},  64'(lv),   64'(e_lv[i]));
      chk({p, ".load_data"},   ld,        e_ld[i]);
      if (e_req[i]) begin
         lm = '0;
         for (int b = 0; b < 8; b++) if (e_mask[i][b]) lm[8*b +: 8] = 8'hFF;
         chk({p, ".mem_we"},    64'(we), 64'(e_we[i]));
         chk({p, ".mem_addr"},  addr,    e_addr[i]);
         chk({p, ".mem_mask"},  64'(mk), 64'(e_mask[i]));
         chk({p, ".mem_wdata"}, wd & lm, e_wdata[i] & lm);
      end
      if (e_zero[i]) begin
         chk({p, ".rst_mem_we"},    64'(we), 64'd0);
         chk({p, ".rst_mem_addr"},  addr,    64'd0);
         chk({p, ".rst_mem_mask"},  64'(mk), 64'd0);
         chk({p, ".rst_mem_wdata"}, wd,      64'd0);
      end
      stall_seen[i] += int'(stl);
      lv_seen[i]    += int'(lv);
      aerr_seen[i]  += int'(aerr);
      terr_seen[i]  += int'(terr);
      req_seen[i]   += int'(req);
      if (req && !cap_v[i]) begin
         cap_v[i] = 1'b1;
         cap_addr[i] = addr; cap_wdata[i] = wd; cap_mask[i] = mk; cap_we[i] = we;
      end
   endtask

   // Compare process: outputs sampled mid-cycle, away from the rising edge
   always @(negedge clk) begin
      cmp_inst(0, a_stall, a_mem_req, a_access_err, a_timeout_err, a_load_valid, a_mem_we,
               64'(a_load_data), 64'(a_mem_addr), 64'(a_mem_wdata), 8'(a_mem_mask));
      cmp_inst(1, b_stall, b_mem_req, b_access_err, b_timeout_err, b_load_valid, b_mem_we,
               b_load_data, 64'(b_mem_addr), b_mem_wdata, b_mem_mask);
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] opb,
                        input bit ack, input logic [63:0] rd);
      if (i == 0) begin
         a_load = ld; a_store = st; a_funct3 = f3; a_addr = addr[31:0];
         a_op_b = opb[31:0]; a_mem_ack = ack; a_mem_rdata = rd[31:0];
      end else begin
         b_load = ld; b_store = st; b_funct3 = f3; b_addr = addr[31:0];
         b_op_b = opb; b_mem_ack = ack; b_mem_rdata = rd;
      end
   endtask

   task automatic idle(input int i);
      drive(i, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 64'd0);
   endtask

   task automatic clear_exp(input int i);
      e_stall[i] = 1'b0; e_req[i] = 1'b0; e_aerr[i] = 1'b0;
      e_terr[i] = 1'b0; e_lv[i] = 1'b0; e_zero[i] = 1'b0;
   endtask

   task automatic obs_clear(input int i);
      stall_seen[i] = 0; lv_seen[i] = 0; aerr_seen[i] = 0; terr_seen[i] = 0;
      req_seen[i] = 0; cap_v[i] = 1'b0;
   endtask

   // One pipeline access; ack_k = BUSY cycle carrying mem_ack (<=0 means never)
   task automatic access(input int i, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] opb,
                         input logic [63:0] rd, input int ack_k);
      int w, tmo;
      bit done;
      w   = (i == 0) ? 32 : 64;
      tmo = (i == 0) ? 4 : 0;
      obs_clear(i);
      drive(i, ld, st, f3, addr, opb, 1'b0, 64'd0);
      clear_exp(i);
      if (!f_legal(ld, st, f3, addr, w)) begin
         e_aerr[i] = 1'b1;
         tick();
         idle(i); clear_exp(i);
         tick();
         return;
      end
      e_stall[i] = 1'b1;
      tick();
      e_req[i]   = 1'b1;
      e_we[i]    = st;
      e_addr[i]  = f_maddr(addr, w);
      e_mask[i]  = f_mask(f3, addr, w);
      e_wdata[i] = f_wdata(opb, addr, w);
      done = 1'b0;
      for (int k = 1; k <= 200 && !done; k++) begin
         if (k == ack_k) begin
            drive(i, ld, st, f3, addr, opb, 1'b1, rd);
            e_stall[i] = 1'b0;
            tick();
            idle(i); clear_exp(i);
            if (ld) begin
               e_lv[i] = 1'b1;
               e_ld[i] = f_load(rd, f3, addr, w);
            end
            tick();
            e_lv[i] = 1'b0;
            done = 1'b1;
         end else if (tmo != 0 && k == tmo + 1) begin
            e_stall[i] = 1'b0; e_req[i] = 1'b0; e_terr[i] = 1'b1;
            tick();
            idle(i); clear_exp(i);
            tick();
            done = 1'b1;
         end else begin
            e_stall[i] = 1'b1;
            tick();
         end
      end
      chk("access_completed", 64'(done), 64'd1);
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      idle(0); idle(1);
      for (int i = 0; i < 2; i++) begin
         chk_en[i] = 1'b0; clear_exp(i); obs_clear(i);
         e_ld[i] = '0; e_we[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0; e_mask[i] = '0;
      end
      tick(); tick();
      a_rst = 1'b0; b_rst = 1'b0;
      chk_en[0] = 1'b1; chk_en[1] = 1'b1;
      e_zero[0] = 1'b1; e_zero[1] = 1'b1;
      tick();
      e_zero[0] = 1'b0; e_zero[1] = 1'b0;
      tick();

      // LB at 0x103, ack in the fourth BUSY cycle
      access(0, 1, 0, 3'b000, 64'h103, 64'd0, 64'h80FF_FF00, 4);
      chk("lit.lb_addr",  cap_addr[0], 64'h100);
      chk("lit.lb_mask",  64'(cap_mask[0]), 64'h8);
      chk("lit.lb_stall", 64'(stall_seen[0]), 64'd4);
      chk("lit.lb_data",  64'(a_load_data), 64'hFFFF_FF80);
      chk("lit.lb_valid", 64'(lv_seen[0]), 64'd1);

      // SH at 0x202: store leaves load_data alone
      access(0, 0, 1, 3'b001, 64'h202, 64'h0000_ABCD, 64'hFFFF_FFFF, 2);
      chk("lit.sh_mask",  64'(cap_mask[0]), 64'hC);
      chk("lit.sh_wdata", 64'(cap_wdata[0][31:16]), 64'hABCD);
      chk("lit.sh_we",    64'(cap_we[0]), 64'd1);
      chk("lit.sh_valid", 64'(lv_seen[0]), 64'd0);

      // Misaligned LW
      access(0, 1, 0, 3'b010, 64'h101, 64'd0, 64'd0, 1);
      chk("lit.lw_mis_err",   64'(aerr_seen[0]), 64'd1);
      chk("lit.lw_mis_req",   64'(req_seen[0]), 64'd0);
      chk("lit.lw_mis_stall", 64'(stall_seen[0]), 64'd0);

      // No ack: timeout in the fifth BUSY cycle
      access(0, 1, 0, 3'b010, 64'h10, 64'd0, 64'd0, 0);
      chk("lit.tmo_err", 64'(terr_seen[0]), 64'd1);
      chk("lit.tmo_req", 64'(req_seen[0]), 64'd4);

      // Ack exactly when the timeout would fire: ack wins
      access(0, 1, 0, 3'b010, 64'h20, 64'd0, 64'h0BAD_F00D, 5);
      chk("lit.ack_vs_tmo", 64'(terr_seen[0]), 64'd0);

      // More 32-bit patterns
      access(0, 1, 0, 3'b100, 64'h101, 64'd0, 64'h1234_80FF, 1);
      access(0, 1, 0, 3'b101, 64'h102, 64'd0, 64'hBEEF_0000, 1);
      access(0, 1, 0, 3'b001, 64'h102, 64'd0, 64'hBEEF_0000, 3);
      access(0, 1, 0, 3'b010, 64'h104, 64'd0, 64'hCAFE_F00D, 1);
      access(0, 0, 1, 3'b000, 64'h003, 64'h0000_005A, 64'd0, 1);
      access(0, 0, 1, 3'b010, 64'h008, 64'h1122_3344, 64'd0, 2);
      access(0, 1, 1, 3'b000, 64'h000, 64'd0, 64'd0, 1);
      access(0, 1, 0, 3'b111, 64'h000, 64'd0, 64'd0, 1);
      access(0, 0, 1, 3'b100, 64'h000, 64'd0, 64'd0, 1);
      access(0, 1, 0, 3'b011, 64'h000, 64'd0, 64'd0, 1);
      access(0, 1, 0, 3'b001, 64'h201, 64'd0, 64'd0, 1);

      // Reset in the middle of a load, then a late ack
      obs_clear(0);
      drive(0, 1, 0, 3'b010, 64'h40, 64'd0, 1'b0, 64'd0);
      clear_exp(0);
      e_stall[0] = 1'b1;
      tick();
      e_req[0] = 1'b1; e_we[0] = 1'b0; e_addr[0] = 64'h40;
      e_mask[0] = f_mask(3'b010, 64'h40, 32); e_wdata[0] = 64'd0;
      tick(); tick();
      a_rst = 1'b1; chk_en[0] = 1'b0;
      tick();
      a_rst = 1'b0; chk_en[0] = 1'b1;
      drive(0, 0, 0, 3'b000, 64'd0, 64'd0, 1'b1, 64'h1234_5678);
      clear_exp(0);
      e_zero[0] = 1'b1; e_ld[0] = 64'd0;
      tick();
      idle(0);
      tick();
      e_zero[0] = 1'b0;
      tick();
      chk("lit.rst_valid", 64'(lv_seen[0]), 64'd0);
      chk("lit.rst_data",  64'(a_load_data), 64'd0);

      // 64-bit bus
      access(1, 1, 0, 3'b110, 64'h1004, 64'd0, 64'h8000_0001_DEAD_BEEF, 2);
      chk("lit.lwu_mask", 64'(cap_mask[1]), 64'hF0);
      chk("lit.lwu_addr", cap_addr[1], 64'h1000);
      chk("lit.lwu_data", b_load_data, 64'h0000_0000_8000_0001);
      access(1, 1, 0, 3'b011, 64'h1008, 64'd0, 64'h8877_6655_4433_2211, 1);
      access(1, 1, 0, 3'b010, 64'h100C, 64'd0, 64'hF000_0000_1234_5678, 1);
      access(1, 0, 1, 3'b011, 64'h10, 64'h0102_0304_0506_0708, 64'd0, 1);
      access(1, 0, 1, 3'b000, 64'h17, 64'h0000_0000_0000_00AB, 64'd0, 2);
      access(1, 1, 0, 3'b000, 64'h1, 64'd0, 64'h0000_0000_0000_9900, 20);
      chk("lit.no_tmo", 64'(terr_seen[1]), 64'd0);
      access(1, 1, 0, 3'b011, 64'h1004, 64'd0, 64'd0, 1);
      chk("lit.ld_mis_err", 64'(aerr_seen[1]), 64'd1);

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning maximum wait cycles for mem_ack; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 The block SHALL have ports load, input, 1 and store, input, 1, the pipeline access requests.
REQ-007 The block SHALL have port funct3, input, 3, the access size and sign selector.
REQ-008 The block SHALL have port op_b, input, DATA_W, the store data, right-aligned.
REQ-009 The block SHALL have port alu_out_address, input, ADDR_W, the byte address.
REQ-010 The block SHALL have port stall, output, 1, which holds the pipeline; upstream inputs stay stable while it is high.
REQ-011 The block SHALL have ports load_data, output, DATA_W and load_valid, output, 1, the extended load result and its 1-cycle strobe.
REQ-012 The block SHALL have ports access_err, output, 1 and timeout_err, output, 1, 1-cycle error pulses.
REQ-013 The block SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, ADDR_W; mem_mask, output, DATA_W/8; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W; and mem_ack, input, 1.

Function
REQ-014 The FSM SHALL have states IDLE and BUSY.
REQ-015 Legal funct3 encodings SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, plus 011 LD and 110 LWU when DATA_W=64; stores 000 SB, 001 SH, 010 SW, plus 011 SD when DATA_W=64.
REQ-016 A request SHALL be faulty if load and store are both high, funct3 is illegal, or it is misaligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
REQ-017 In IDLE with a faulty request, the block SHALL pulse access_err for 1 cycle, issue no mem_req, keep stall low, and stay in IDLE.
REQ-018 In IDLE with a legal request, the block SHALL register the request attributes and go to BUSY; stall is high combinationally in that cycle.
REQ-019 In BUSY, the block SHALL hold mem_req=1 and keep mem_we, mem_addr, mem_mask and mem_wdata constant from the registered copy.
REQ-020 mem_addr SHALL be the request address with its low log2(DATA_W/8) bits zeroed.
REQ-021 mem_mask SHALL be 1, 2, 4 or 8 contiguous ones shifted left by the lane offset, the low address bits.
REQ-022 mem_wdata SHALL be op_b shifted left by 8 times the lane offset; unselected lanes are don't-care.
REQ-023 In BUSY, stall SHALL be high except in the cycle mem_ack=1, where stall=0 and the next state is IDLE; minimum access latency is therefore 2 cycles (launch cycle plus ack cycle).
REQ-024 On a load ack, the block SHALL right-shift mem_rdata by the lane offset and sign- or zero-extend it per funct3, register the result into load_data, and pulse load_valid in the following cycle.
REQ-025 load_data SHALL hold its value until the next load completes; a store ack SHALL leave load_data unchanged and not pulse load_valid.
REQ-026 The wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-027 If TIMEOUT_CYC is nonzero and the counter reaches TIMEOUT_CYC, the block SHALL pulse timeout_err, drop mem_req, lower stall and return to IDLE that cycle; an ack in the same cycle takes priority over the timeout.
REQ-028 mem_ack SHALL be ignored in IDLE.
REQ-029 load and store arriving in the same cycle as a completing ack SHALL be sampled only from the next cycle in IDLE.

Reset
REQ-030 On rst, the block SHALL go to IDLE, clear the counter, and drive stall, mem_req, mem_we, mem_addr, mem_mask, mem_wdata, load_data, load_valid, access_err and timeout_err to 0 from the next cycle.
REQ-031 rst SHALL override every other input, including a reset applied mid-BUSY; the outstanding access is abandoned and a late mem_ack is ignored.

Verification
REQ-032 A bench SHALL cover: DATA_W=32, LB at address 0x103, mem_rdata=0x80FF_FF00, ack 3 cycles later -> mem_addr=0x100, mask=1000, stall high for 4 cycles, load_data=0xFFFF_FF80.
REQ-033 A bench SHALL cover: SH at 0x202, op_b=0x0000_ABCD -> mem_mask=1100, mem_wdata[31:16]=0xABCD, mem_we=1, no load_valid.
REQ-034 A bench SHALL cover: LW at 0x101 -> access_err pulse, mem_req never rises, stall low.
REQ-035 A bench SHALL cover: TIMEOUT_CYC=4 with no ack -> timeout_err in the 5th BUSY cycle, mem_req low afterwards.
REQ-036 A bench SHALL cover: DATA_W=64, LWU at 0x1004, mem_rdata[63:32]=0x8000_0001 -> mask=0xF0, load_data=0x0000_0000_8000_0001.
REQ-037 A bench SHALL cover: rst asserted during BUSY, then mem_ack -> all outputs 0, no load_valid.
